arm_id_control_stage: RTL and testbench
=======================================

Name: arm_id_control_stage

Overview:
- Instruction-decode control block for the 5-stage ARM pipeline.
- Three functions:
  - PC+4 incrementer (combinational).
  - ARM-subset control decoder for the instruction held in the ID stage.
  - Hazard/bubble mux that forces all control signals to zero.
- The muxed control bundle is registered once, and that register feeds the ID/EX stage.

Parameters:
- DATA_WIDTH, 32, width of the PC and instruction buses.
- PC_INCREMENT, 4, constant added to pc_current.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all registered outputs.
- pc_current  in  DATA_WIDTH  current program counter.
- pc_plus_4  out  DATA_WIDTH  pc_current + PC_INCREMENT (combinational).
- instruction  in  32  instruction in the ID stage.
- hazard_select  in  1  1 = insert bubble (all control signals zeroed).
- reg_write_enable  out  1  register-file write enable.
- mem_enable  out  1  data-memory access enable.
- mem_rw  out  1  1 = store/write, 0 = load/read.
- mem_size  out  1  1 = byte, 0 = word.
- mem_to_reg_select  out  1  writeback data comes from memory.
- alu_source_select  out  1  1 = immediate/shifter operand.
- status_bit  out  1  update condition flags.
- alu_operation  out  4  ALU opcode.
- pc_source_select  out  1  branch taken-path select (B/BL).

Behaviour:
- pc_plus_4 is combinational: pc_current + PC_INCREMENT, modulo 2^DATA_WIDTH. 0xFFFFFFFC + 4 = 0x00000000; no carry out.
- Decode is combinational on instruction. The condition field [31:28] is ignored; condition evaluation happens elsewhere.
- NOP (instruction == 0): all control signals are 0.
- Data processing ([27:26]=00, nonzero):
  - alu_operation = [24:21].
  - status_bit = [20].
  - alu_source_select = [25].
  - reg_write_enable = 1, except opcodes 1000–1011 (TST/TEQ/CMP/CMN), which give 0.
  - mem_* = 0, mem_to_reg_select = 0, pc_source_select = 0.
- Load/store ([27:26]=01):
  - mem_enable = 1.
  - L = [20]: mem_rw = ~L, reg_write_enable = L, mem_to_reg_select = L.
  - mem_size = [22].
  - alu_source_select = ~[25].
  - alu_operation = 0100 (ADD) if U = [23] is 1, else 0010 (SUB).
  - status_bit = 0, pc_source_select = 0.
- Branch ([27:25]=101):
  - pc_source_select = 1.
  - reg_write_enable = [24] (BL writes LR).
  - alu_operation = 0100.
  - All other signals 0.
- All other encodings ([27:26]=11, [27:25]=100): treated as NOP, all control signals 0.
- Hazard mux: if hazard_select = 1, every control signal is forced to 0 before the register. If 0, the decoded values pass unchanged.
- Output register:
  - All control outputs update on the rising clk edge from the muxed decode; latency is 1 cycle from instruction/hazard_select.
  - If reset is high at an edge, all control outputs become 0 regardless of instruction or hazard_select.
  - Reset has priority over hazard_select.
  - Reset asserted mid-stream clears outputs at the next edge; decode resumes on the first edge after reset deasserts.
- No X propagation: every output is defined for every instruction value.

Test Plan:
- reset=1 for 2 edges with instruction=0xE2110000 -> all control outputs 0. Deassert reset -> next edge: reg_write_enable=1, status_bit=1, alu_source_select=1, alu_operation=0000, mem_enable=0.
- instruction=0xE0805183 (ADD) -> after 1 edge: reg_write_enable=1, alu_operation=0100, alu_source_select=0, status_bit=0. Then 0xE2010000 (AND) -> status_bit=0, alu_source_select=1.
- instruction=0xE7D12000 (LDRB) -> mem_enable=1, mem_rw=0, mem_size=1, mem_to_reg_select=1, reg_write_enable=1, alu_source_select=0, alu_operation=0100. Then 0xE58A5000 (STR) -> mem_enable=1, mem_rw=1, mem_size=0, reg_write_enable=0, alu_source_select=1.
- instruction=0x1AFFFFFD (BNE) -> pc_source_select=1, reg_write_enable=0. Then 0xDB000009 (BLLE) -> pc_source_select=1, reg_write_enable=1. Then 0x00000000 -> all outputs 0.
- hazard_select=1 with instruction=0xE7D12000 -> next edge: all outputs 0. Drop hazard_select -> following edge: LDRB values reappear.
- pc_current=0x00000010 -> pc_plus_4=0x00000014 with no clock needed. pc_current=0xFFFFFFFC -> pc_plus_4=0x00000000.

Source files
------------

// File: rtl/arm_id_control_stage.sv
// arm_id_control_stage
//   Instruction-decode control block for the 5-stage ARM pipeline.
//   - pc_plus_4: combinational pc_current + PC_INCREMENT (wraps, no carry out).
//   - Decodes the ARM subset (data processing, single load/store, B/BL) held
//     in the ID stage into a control bundle. Everything else decodes as a NOP.
//   - hazard_select forces a bubble (all-zero bundle) ahead of the register.
//   - The muxed bundle is registered once and drives the ID/EX stage.
// Ports
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   pc_current/pc_plus_4 : PC in, PC + PC_INCREMENT out
//   instruction          : instruction in the ID stage
//   hazard_select        : 1 = insert bubble
//   reg_write_enable .. pc_source_select : registered control outputs
module arm_id_control_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int PC_INCREMENT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pc_current,
  output logic [DATA_WIDTH-1:0] pc_plus_4,
  input  logic [31:0]           instruction,
  input  logic                  hazard_select,
  output logic                  reg_write_enable,
  output logic                  mem_enable,
  output logic                  mem_rw,
  output logic                  mem_size,
  output logic                  mem_to_reg_select,
  output logic                  alu_source_select,
  output logic                  status_bit,
  output logic [3:0]            alu_operation,
  output logic                  pc_source_select
);

  typedef struct packed {
    logic       reg_write_enable;
    logic       mem_enable;
    logic       mem_rw;
    logic       mem_size;
    logic       mem_to_reg_select;
    logic       alu_source_select;
    logic       status_bit;
    logic [3:0] alu_operation;
    logic       pc_source_select;
  } ctrl_t;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  ctrl_t dec, muxed, ctrl_q;

  // Sum is taken at DATA_WIDTH bits, so the carry out is simply dropped.
  assign pc_plus_4 = pc_current + DATA_WIDTH'(PC_INCREMENT);

  // Condition field [31:28] is deliberately ignored; it is evaluated downstream.
  always_comb begin
    dec = '0;
    if (instruction != 32'h0) begin
      if (instruction[27:26] == 2'b00) begin
        // Data processing. TST/TEQ/CMP/CMN (1000-1011) only set flags.
        dec.alu_operation     = instruction[24:21];
        dec.status_bit        = instruction[20];
        dec.alu_source_select = instruction[25];
        dec.reg_write_enable  = (instruction[24:23] != 2'b10);
      end else if (instruction[27:26] == 2'b01) begin
        // Single load/store. I=0 means immediate offset, hence the inversion.
        dec.mem_enable        = 1'b1;
        dec.mem_rw            = ~instruction[20];
        dec.reg_write_enable  = instruction[20];
        dec.mem_to_reg_select = instruction[20];
        dec.mem_size          = instruction[22];
        dec.alu_source_select = ~instruction[25];
        dec.alu_operation     = instruction[23] ? ALU_ADD : ALU_SUB;
      end else if (instruction[27:25] == 3'b101) begin
        // B/BL: the L bit makes BL write the link register.
        dec.pc_source_select  = 1'b1;
        dec.reg_write_enable  = instruction[24];
        dec.alu_operation     = ALU_ADD;
      end
    end
  end

  assign muxed = hazard_select ? ctrl_t'('0) : dec;

  always_ff @(posedge clk) begin
    if (reset) ctrl_q <= '0;
    else       ctrl_q <= muxed;
  end

  assign reg_write_enable  = ctrl_q.reg_write_enable;
  assign mem_enable        = ctrl_q.mem_enable;
  assign mem_rw            = ctrl_q.mem_rw;
  assign mem_size          = ctrl_q.mem_size;
  assign mem_to_reg_select = ctrl_q.mem_to_reg_select;
  assign alu_source_select = ctrl_q.alu_source_select;
  assign status_bit        = ctrl_q.status_bit;
  assign alu_operation     = ctrl_q.alu_operation;
  assign pc_source_select  = ctrl_q.pc_source_select;

endmodule

// File: tb/tb_arm_id_control_stage.sv
// Directed-vector bench for arm_id_control_stage. Control outputs are compared
// as one 12-bit bundle: {rwe, men, mrw, msz, m2r, asrc, sb, aluop[3:0], pcs}.
module tb_arm_id_control_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_current;
  logic [31:0] pc_plus_4;
  logic [31:0] instruction;
  logic        hazard_select;
  logic        reg_write_enable, mem_enable, mem_rw, mem_size;
  logic        mem_to_reg_select, alu_source_select, status_bit, pc_source_select;
  logic [3:0]  alu_operation;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  arm_id_control_stage #(.DATA_WIDTH(32), .PC_INCREMENT(4)) dut (
    .clk(clk), .reset(reset), .pc_current(pc_current), .pc_plus_4(pc_plus_4),
    .instruction(instruction), .hazard_select(hazard_select),
    .reg_write_enable(reg_write_enable), .mem_enable(mem_enable), .mem_rw(mem_rw),
    .mem_size(mem_size), .mem_to_reg_select(mem_to_reg_select),
    .alu_source_select(alu_source_select), .status_bit(status_bit),
    .alu_operation(alu_operation), .pc_source_select(pc_source_select)
  );

  logic [11:0] ctrl;
  assign ctrl = {reg_write_enable, mem_enable, mem_rw, mem_size, mem_to_reg_select,
                 alu_source_select, status_bit, alu_operation, pc_source_select};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic apply(input string tag, input logic [31:0] instr, input logic hz,
                       input logic rst, input logic [11:0] exp);
    instruction   = instr;
    hazard_select = hz;
    reset         = rst;
    @(posedge clk);
    #1;
    chk(tag, {20'h0, ctrl}, {20'h0, exp});
  endtask

  //                            rwe men mrw msz m2r asrc sb  op      pcs
  localparam logic [11:0] C_ZERO = 12'b0;
  localparam logic [11:0] C_TSTI = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,4'b0000,1'b0}; // E2110000
  localparam logic [11:0] C_ADD  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0100,1'b0};
  localparam logic [11:0] C_AND  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0000,1'b0};
  localparam logic [11:0] C_CMP  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,4'b1010,1'b0};
  localparam logic [11:0] C_LDRB = {1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,4'b0100,1'b0};
  localparam logic [11:0] C_STR  = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,4'b0100,1'b0};
  localparam logic [11:0] C_LDRD = {1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,4'b0010,1'b0}; // U=0
  localparam logic [11:0] C_BNE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0100,1'b1};
  localparam logic [11:0] C_BL   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0100,1'b1};

  initial begin
    reset = 1'b1; hazard_select = 1'b0; instruction = 32'hE211_0000; pc_current = 32'h0;

    // Reset held for two edges with a flag-setting instruction present.
    apply("reset_e1", 32'hE211_0000, 1'b0, 1'b1, C_ZERO);
    apply("reset_e2", 32'hE211_0000, 1'b0, 1'b1, C_ZERO);
    apply("rst_rel",  32'hE211_0000, 1'b0, 1'b0, C_TSTI);

    // Data processing
    apply("add",  32'hE080_5183, 1'b0, 1'b0, C_ADD);
    apply("and",  32'hE201_0000, 1'b0, 1'b0, C_AND);
    apply("cmp",  32'hE351_0000, 1'b0, 1'b0, C_CMP);

    // Load/store
    apply("ldrb", 32'hE7D1_2000, 1'b0, 1'b0, C_LDRB);
    apply("str",  32'hE58A_5000, 1'b0, 1'b0, C_STR);
    apply("ldr_d",32'hE511_2004, 1'b0, 1'b0, C_LDRD);

    // Branches, condition field ignored
    apply("bne",  32'h1AFF_FFFD, 1'b0, 1'b0, C_BNE);
    apply("blle", 32'hDB00_0009, 1'b0, 1'b0, C_BL);
    apply("nop",  32'h0000_0000, 1'b0, 1'b0, C_ZERO);

    // Unsupported encodings decode as NOP
    apply("cp",   32'hEE00_0000, 1'b0, 1'b0, C_ZERO);
    apply("ldm",  32'hE8BD_0000, 1'b0, 1'b0, C_ZERO);

    // Hazard bubble then recovery
    apply("ldrb_pre", 32'hE7D1_2000, 1'b0, 1'b0, C_LDRB);
    apply("bubble",   32'hE7D1_2000, 1'b1, 1'b0, C_ZERO);
    apply("unbubble", 32'hE7D1_2000, 1'b0, 1'b0, C_LDRB);

    // Reset mid-stream, and with hazard_select also high
    apply("rst_mid",  32'hE7D1_2000, 1'b0, 1'b1, C_ZERO);
    apply("rst_hz",   32'hDB00_0009, 1'b1, 1'b1, C_ZERO);
    apply("resume",   32'hDB00_0009, 1'b0, 1'b0, C_BL);

    // Combinational PC incrementer, no clock edge
    pc_current = 32'h0000_0010; #1;
    chk("pc4_a", pc_plus_4, 32'h0000_0014);
    pc_current = 32'hFFFF_FFFC; #1;
    chk("pc4_wrap", pc_plus_4, 32'h0000_0000);
    pc_current = 32'h7FFF_FFFE; #1;
    chk("pc4_b", pc_plus_4, 32'h8000_0002);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
